// File: rtl/irq_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

    localparam int NUM_IRQ        = 4;
    localparam int IRQ_IDW        = 2;
    localparam int DEF_VEC_BASE   = 'h3F0;
    localparam int DEF_VEC_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } irq_state_e;

    // Convert a source index into a one-hot bit mask over the source lines.
    function automatic logic [NUM_IRQ-1:0] id2mask(input logic [IRQ_IDW-1:0] id);
        logic [NUM_IRQ-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Purpose: bundle of CPU/interrupt-line signals between the controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; int_req is held until the CPU pulses int_ack.
// Ports: irq/mask_we/mask_d/int_ack/int_ret flow master->slave; int_req/int_vec/int_id/
//        pending/in_service flow slave->master. The controller is the slave.
interface irq_ctrl_if #(
    parameter int AW = 10
);
    import irq_pkg::*;

    logic [NUM_IRQ-1:0] irq;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_d;
    logic               int_ack;
    logic               int_ret;
    logic               int_req;
    logic [AW-1:0]      int_vec;
    logic [IRQ_IDW-1:0] int_id;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;

    modport master (
        output irq, mask_we, mask_d, int_ack, int_ret,
        input  int_req, int_vec, int_id, pending, in_service
    );

    modport slave (
        input  irq, mask_we, mask_d, int_ack, int_ret,
        output int_req, int_vec, int_id, pending, in_service
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Purpose: combinational fixed-priority encoder, bit 0 has highest priority.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: req (4-bit request vector) -> vld (any bit set), idx (lowest set bit index).
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               vld,
    output logic [IRQ_IDW-1:0] idx
);

    always_comb begin
        vld = 1'b1;
        idx = '0;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: begin
                vld = 1'b0;
                idx = '0;
            end
        endcase
    end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose: 4-source rising-edge interrupt controller with mask, fixed priority and vectoring.
// Latency: irq rise -> pending next edge -> int_req the edge after (2 clocks minimum).
// Backpressure: request is frozen until int_ack; no nesting until int_ret.
// Ports: clk, reset (sync, active-high); bus (irq_ctrl_if.slave) carries irq lines, mask
//        write, CPU ack/ret pulses and the req/vec/id/pending/in_service outputs.
module irq_ctrl #(
    parameter int          AW         = 10,
    parameter int unsigned VEC_BASE   = irq_pkg::DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE = irq_pkg::DEF_VEC_STRIDE
) (
    input  logic       clk,
    input  logic       reset,
    irq_ctrl_if.slave  bus
);
    import irq_pkg::*;

    // Address arithmetic is done at AW bits so the result wraps naturally.
    localparam logic [AW-1:0] BASE_AW   = AW'(VEC_BASE);
    localparam logic [AW-1:0] STRIDE_AW = AW'(VEC_STRIDE);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [IRQ_IDW-1:0] id_q, id_d;
    logic [AW-1:0]      vec_q, vec_d;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pend_clr;
    logic               enc_vld;
    logic [IRQ_IDW-1:0] enc_idx;

    // Only enabled sources compete; masked ones keep accumulating in pending_q.
    irq_prio_enc u_prio_enc (
        .req (pending_q & mask_q),
        .vld (enc_vld),
        .idx (enc_idx)
    );

    always_comb begin
        irq_d    = bus.irq;
        irq_rise = bus.irq & ~irq_q;
        mask_d   = bus.mask_we ? bus.mask_d : mask_q;
        pend_clr = '0;
        state_d  = state_q;
        id_d     = id_q;
        vec_d    = vec_q;

        unique case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    state_d = REQ;
                    id_d    = enc_idx;
                    vec_d   = BASE_AW + AW'(enc_idx) * STRIDE_AW;
                end
            end
            REQ: begin
                // id/vec stay latched here; later edges or mask writes cannot retarget.
                if (bus.int_ack) begin
                    state_d  = SERV;
                    pend_clr = id2mask(id_q);
                end
            end
            SERV: begin
                if (bus.int_ret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the source being acknowledged must survive the clear.
        pending_d = (pending_q & ~pend_clr) | irq_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            // Lines already high during reset must not look like a new edge afterwards.
            irq_q     <= bus.irq;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            vec_q     <= BASE_AW;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
        end
    end

    assign bus.int_req    = (state_q == REQ);
    assign bus.in_service = (state_q == SERV);
    assign bus.int_id     = id_q;
    assign bus.int_vec    = vec_q;
    assign bus.pending    = pending_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter AW, default 10, SHALL set the width of the CPU program-address vector output.
REQ-002 Parameter VEC_BASE, default 10'h3F0, SHALL set the handler address for source 0.
REQ-003 Parameter VEC_STRIDE, default 4, SHALL set the address spacing between successive source handlers.
REQ-004 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 irq  input  4  SHALL carry the raw interrupt request lines; they are rising-edge sensitive and irq[0] is highest priority.
REQ-007 mask_we  input  1  SHALL be the mask write strobe.
REQ-008 mask_d  input  4  SHALL be the mask write data; bit=1 enables that source.
REQ-009 int_ack  input  1  SHALL be a CPU pulse meaning "vector taken, entering handler".
REQ-010 int_ret  input  1  SHALL be a CPU pulse meaning "return from interrupt executed".
REQ-011 int_req  output  1  SHALL be the interrupt request to the CPU.
REQ-012 int_vec  output  AW  SHALL be the handler address, valid while int_req=1.
REQ-013 int_id  output  2  SHALL be the index of the requesting or in-service source.
REQ-014 pending  output  4  SHALL expose the pending-event register.
REQ-015 in_service  output  1  SHALL be 1 while a handler is running.

Function
REQ-016 irq_q SHALL register irq each cycle; an edge on source i SHALL be detected when irq[i]=1 and irq_q[i]=0.
REQ-017 A detected edge SHALL set pending[i] on the next clock; level-high input with no new edge SHALL NOT re-set a cleared bit.
REQ-018 If set and clear of the same pending bit occur in the same cycle, set SHALL win.
REQ-019 Mask writes SHALL take effect on the clock after mask_we=1; masked sources SHALL still accumulate pending bits.
REQ-020 The FSM SHALL have exactly three states: IDLE, REQ and SERV.
REQ-021 IDLE: if (pending & mask)!=0, the FSM SHALL go to REQ and latch int_id = lowest set index and int_vec = VEC_BASE + int_id*VEC_STRIDE (truncated to AW).
REQ-022 REQ: int_req SHALL be 1, and int_id and int_vec SHALL stay frozen; a later higher-priority edge or mask change SHALL NOT alter or withdraw the request.
REQ-023 REQ with int_ack=1: the FSM SHALL go to SERV and clear pending[int_id] on the same clock edge.
REQ-024 SERV: in_service SHALL be 1 and int_req 0; no nesting; int_ret=1 SHALL return the FSM to IDLE.
REQ-025 int_ack outside REQ and int_ret outside SERV SHALL be ignored.
REQ-026 Latency: irq edge sampled at edge n, pending set at n+1, int_req high after edge n+2 (minimum).
REQ-027 Back-to-back: with another enabled source pending at int_ret, int_req SHALL reassert two clocks after int_ret (SERV->IDLE->REQ).

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL load: state=IDLE, pending=0, mask=0, irq_q=irq, int_req=0, in_service=0, int_id=0, int_vec=VEC_BASE.
REQ-029 Reset asserted mid-REQ or mid-SERV SHALL abort the request/service with no pending bit retained.
REQ-030 Loading irq_q from irq at reset SHALL prevent lines already high at reset release from producing an edge.

Structure
REQ-031 Package irq_pkg SHALL hold NUM_IRQ=4, the FSM state typedef (IDLE/REQ/SERV), and default VEC_BASE/VEC_STRIDE constants.
REQ-032 The design SHALL contain one sub-module, irq_prio_enc: a combinational 4-bit fixed-priority encoder producing a valid flag and a 2-bit index.

Verification
REQ-033 Reset release with irq=4'b0010 held high, mask=4'hF -> no int_req ever asserts.
REQ-034 mask=4'hF, pulse irq[2] -> int_req two clocks later, int_id=2, int_vec=10'h3F8; int_ack -> pending=0, in_service=1; int_ret -> IDLE.
REQ-035 Edges on irq[3] and irq[1] in the same cycle -> int_id=1 first; after int_ack and int_ret, int_id=3, int_vec=10'h3FC.
REQ-036 mask=4'b0000, pulse irq[0] -> pending=4'b0001 and no int_req; write mask=4'b0001 -> int_req two clocks after mask_we.
REQ-037 New irq[1] edge coinciding with int_ack of source 1 -> pending[1] stays 1 and source 1 is re-requested after int_ret.
REQ-038 reset pulsed while in SERV -> in_service=0, pending=0, mask=0 next clock; stray int_ret is ignored.
